// File: rtl/cuatro_a.sv
// cuatro_a: six-input vote/parity evaluator.
// Each cycle it samples {a,b,c,d,e,f}. x reports whether at least THRESHOLD
// of them are set, y reports their odd parity. Both outputs are registered,
// so they only change on a clock edge or when rst is asserted.
module cuatro_a #(
  parameter int THRESHOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic x,
  output logic y
);

  localparam int NUM_IN = 6;

  logic [NUM_IN-1:0] vec;
  logic [2:0]        cnt;
  logic              x_n;
  logic              y_n;

  assign vec = {a, b, c, d, e, f};

  // Population count of the sampled bits (0..6 fits in 3 bits).
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_IN; i++) cnt = cnt + {2'b00, vec[i]};
  end

  // Threshold vote and parity. The comparison is done at full integer width,
  // so THRESHOLD=0 always votes and THRESHOLD>=7 never does. Parity is the
  // LSB of the count.
  always_comb begin
    x_n = ($signed({29'd0, cnt}) >= THRESHOLD);
    y_n = cnt[0];
  end

  // Output register. Reset forces both outputs low at once and drops the pending sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= 1'b0;
      y <= 1'b0;
    end else begin
      x <= x_n;
      y <= y_n;
    end
  end

endmodule

// File: tb/tb_cuatro_a.sv
// Self-checking bench for cuatro_a.
// It runs three instances: THRESHOLD 4 as the main device, plus 0 and 7 for the boundary cases.
module tb_cuatro_a;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d, e, f;
  logic x, y, x0, y0, x7, y7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cuatro_a #(.THRESHOLD(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .x(x), .y(y)
  );
  cuatro_a #(.THRESHOLD(0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .x(x0), .y(y0)
  );
  cuatro_a #(.THRESHOLD(7)) dut7 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .x(x7), .y(y7)
  );

  typedef struct {
    logic [5:0] v;
    logic       ex;
    logic       ey;
  } vec_t;

  vec_t tbl [6];

  // Reference model: count the set bits, then compare against the threshold.
  function automatic logic model_x(logic [5:0] v, int th);
    int n = 0;
    for (int i = 0; i < 6; i++) if (v[i]) n++;
    return (n >= th);
  endfunction

  function automatic logic model_y(logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) if (v[i]) n++;
    return (n % 2 == 1);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a vector away from the edge, then sample just after the next rising edge.
  task automatic apply(input logic [5:0] v);
    @(negedge clk);
    {a, b, c, d, e, f} = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] v;

    tbl[0] = '{6'b000000, 1'b0, 1'b0};
    tbl[1] = '{6'b000111, 1'b0, 1'b1};
    tbl[2] = '{6'b001111, 1'b1, 1'b0};
    tbl[3] = '{6'b111110, 1'b1, 1'b1};
    tbl[4] = '{6'b111111, 1'b1, 1'b0};
    tbl[5] = '{6'b100000, 1'b0, 1'b1};

    // Reset is asserted before any clock edge, so the outputs must already be low.
    rst = 1'b1;
    {a, b, c, d, e, f} = 6'b111111;
    #1;
    check("reset_x", x, 1'b0);
    check("reset_y", y, 1'b0);
    check("reset_x_th0", x0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold_x", x, 1'b0);
    check("reset_hold_y", y, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].v);
      check($sformatf("tbl%0d_x", i), x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), y, tbl[i].ey);
    end

    // Assert reset in mid-cycle while x=1,y=1; the clear must not wait for an edge.
    apply(6'b111110);
    check("pre_midrst_x", x, 1'b1);
    check("pre_midrst_y", y, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_x", x, 1'b0);
    check("midrst_y", y, 1'b0);

    // Hold 010101 through the reset release; valid outputs appear only after the first edge.
    @(negedge clk);
    {a, b, c, d, e, f} = 6'b010101;
    @(posedge clk); #1;
    check("rst_held_x", x, 1'b0);
    check("rst_held_y", y, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_x", x, 1'b0);
    check("release_y", y, 1'b0);
    @(posedge clk); #1;
    check("first_edge_x", x, 1'b0);
    check("first_edge_y", y, 1'b1);

    // Exhaustive sweep, including both threshold boundary instances.
    for (int k = 0; k < 64; k++) begin
      v = 6'(k);
      apply(v);
      check($sformatf("sweep%0d_x", k), x, model_x(v, 4));
      check($sformatf("sweep%0d_y", k), y, model_y(v));
      check($sformatf("sweep%0d_x_th0", k), x0, 1'b1);
      check($sformatf("sweep%0d_x_th7", k), x7, 1'b0);
      check($sformatf("sweep%0d_y_th0", k), y0, model_y(v));
    end

    // Back-to-back random vectors, so each output depends only on the previous edge.
    for (int k = 0; k < 300; k++) begin
      v = 6'($urandom_range(0, 63));
      apply(v);
      check("rand_x", x, model_x(v, 4));
      check("rand_y", y, model_y(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
